// File: rtl/sevenseg_scan.sv
// Scanned N-digit common-anode 7-segment driver with a double-buffered value and blanking between digits.
// Define SEVENSEG_LZ_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module sevenseg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  output logic [7:0]              leds,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h18;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [7:0]              leds_q, leds_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_q, frame_d;
  logic [3:0]              nib;
  logic [6:0]              seg;
  logic                    lz_blank;
  logic                    show;

  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
    end
    // frame_q high means this edge closes the scan: swap in the newest data.
    if (frame_q) begin
      act_val_d = load ? value : pend_val_q;
      act_dp_d  = load ? dp : pend_dp_q;
    end

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    nib = act_val_q[{idx_q, 2'b00} +: 4];
`ifdef SEVENSEG_LZ_BLANK_EN
    lz_blank = (idx_q != '0) && ((act_val_q >> {idx_q, 2'b00}) == '0);
`else
    lz_blank = 1'b0;
`endif
    seg  = lz_blank ? 7'h7F : font(nib);
    show = int'(cnt_q) >= BLANK;

    leds_d     = 8'hFF;
    digit_en_d = '1;
    if (show) begin
      leds_d               = {~act_dp_q[idx_q], seg};
      digit_en_d[idx_q]    = 1'b0;
    end
    frame_d = (idx_q == IDX_MAX) && (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      leds_q     <= 8'hFF;
      digit_en_q <= '1;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      leds_q     <= leds_d;
      digit_en_q <= digit_en_d;
      frame_q    <= frame_d;
    end
  end

  assign leds     = leds_q;
  assign digit_en = digit_en_q;
  assign frame    = frame_q;

endmodule
